// File: rtl/load_store_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : load_store_unit_if                                               |
// | Brief    : Pipeline request/response and data-memory bus of the LSU.        |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface load_store_unit_if;
    // Pipeline side
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    // Data-memory side
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    // Master is the environment: the pipeline issuing requests plus the memory.
    modport master (
        output req, we, size, unsigned_ld, addr, wdata, mem_read_data,
        input  busy, done, err, rdata, mem_address, mem_write_data, mem_write, mem_read
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata, mem_read_data,
        output busy, done, err, rdata, mem_address, mem_write_data, mem_write, mem_read
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : load_store_unit                                                  |
// | Brief    : Byte/half/word load-store unit with read-modify-write sub-word   |
// |            stores and alignment/bounds checking.                            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    localparam logic [1:0]  c_SIZE_BYTE  = 2'b00;
    localparam logic [1:0]  c_SIZE_HALF  = 2'b01;
    localparam logic [1:0]  c_SIZE_WORD  = 2'b10;
    localparam logic [1:0]  c_SIZE_RSVD  = 2'b11;
    localparam logic [31:0] c_ADDR_LIMIT = 32'(ADDR_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata_lo;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    always_comb begin
        w_req_err = 1'b0;
        if (bus.size == c_SIZE_RSVD)                              w_req_err = 1'b1;
        if ((bus.size == c_SIZE_HALF) && bus.addr[0])             w_req_err = 1'b1;
        if ((bus.size == c_SIZE_WORD) && (bus.addr[1:0] != 2'b00)) w_req_err = 1'b1;
        if (bus.addr >= c_ADDR_LIMIT)                             w_req_err = 1'b1;
    end

    // Little-endian lane pick for loads; sign fill unless a zero-extending load.
    always_comb begin
        w_byte = bus.mem_read_data[{r_offset, 3'b000} +: 8];
        w_half = bus.mem_read_data[{r_offset[1], 4'b0000} +: 16];
        case (r_size)
            c_SIZE_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_load_data = bus.mem_read_data;
        endcase
    end

    // Captured memory word with only the addressed lane overwritten.
    always_comb begin
        w_merged = bus.mem_read_data;
        if (r_size == c_SIZE_BYTE) begin
            w_merged[{r_offset, 3'b000} +: 8] = r_wdata_lo[7:0];
        end else begin
            w_merged[{r_offset[1], 4'b0000} +: 16] = r_wdata_lo;
        end
    end

    // All outputs are registered and set on the edge that enters the state
    // they belong to, so they line up exactly with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_size             <= 2'b00;
            r_unsigned         <= 1'b0;
            r_offset           <= 2'b00;
            r_wdata_lo         <= 16'h0000;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.err            <= 1'b0;
            bus.rdata          <= 32'h0000_0000;
            bus.mem_address    <= 32'h0000_0000;
            bus.mem_write_data <= 32'h0000_0000;
            bus.mem_write      <= 1'b0;
            bus.mem_read       <= 1'b0;
        end else begin
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_size     <= bus.size;
                        r_unsigned <= bus.unsigned_ld;
                        r_offset   <= bus.addr[1:0];
                        r_wdata_lo <= bus.wdata[15:0];
                        bus.busy   <= 1'b1;
                        if (w_req_err) begin
                            r_state  <= S_ERR;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            bus.mem_address <= {bus.addr[31:2], 2'b00};
                            if (!bus.we) begin
                                r_state      <= S_LOAD;
                                bus.mem_read <= 1'b1;
                            end else if (bus.size == c_SIZE_WORD) begin
                                r_state            <= S_STORE;
                                bus.mem_write      <= 1'b1;
                                bus.mem_write_data <= bus.wdata;
                            end else begin
                                r_state      <= S_RMW_RD;
                                bus.mem_read <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    bus.rdata <= w_load_data;
                    bus.done  <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_STORE: begin
                    bus.done <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RMW_RD: begin
                    bus.mem_write_data <= w_merged;
                    bus.mem_write      <= 1'b1;
                    r_state            <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    bus.done <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP, S_ERR: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                               |
// | Brief    : Table-driven, scoreboard-checked bench for load_store_unit.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wr;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        int          wr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          errors;
    int          wr_cnt;
    logic [31:0] model_rdata;
    logic [31:0] mem [0:255];
    exp_t        sb [$];
    vec_t        tbl [18];

    load_store_unit_if bus ();

    load_store_unit #(.ADDR_LIMIT(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_read_data = mem[bus.mem_address[9:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every done.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_write) wr_cnt++;
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_err", {31'd0, bus.err}, {31'd0, e.err});
                chk("done_rdata", bus.rdata, e.rdata);
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("write_count", 32'(wr_cnt), 32'(e.wr));
            end
            wr_cnt = 0;
        end
    end

    task automatic drive(input vec_t v);
        bus.we          = v.we;
        bus.size        = v.size;
        bus.unsigned_ld = v.uns;
        bus.addr        = v.addr;
        bus.wdata       = v.wdata;
        bus.req         = 1'b1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        if (!v.we && !v.err) model_rdata = v.rdata;
        e.err   = v.err;
        e.rdata = model_rdata;
        e.acc   = cyc + 1;
        e.lat   = v.lat;
        e.wr    = v.wr;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        drive(v);
        push(v);
        @(negedge clk);
        bus.req = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        cyc = 0; checks = 0; errors = 0; wr_cnt = 0; model_rdata = 32'h0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.unsigned_ld = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h0000_000A;
        mem[1]   = 32'h80FF_7F01;
        mem[2]   = 32'h1122_3344;
        mem[3]   = 32'h0BAD_F00D;
        mem[255] = 32'h1234_5678;

        //          we size  uns addr          wdata         err rdata          lat wr
        tbl[0]  = '{0, 2'b10, 0, 32'h0,        32'h0,         0, 32'h0000_000A, 2, 0};
        tbl[1]  = '{0, 2'b00, 0, 32'h6,        32'h0,         0, 32'hFFFF_FFFF, 2, 0};
        tbl[2]  = '{0, 2'b00, 1, 32'h6,        32'h0,         0, 32'h0000_00FF, 2, 0};
        tbl[3]  = '{0, 2'b01, 0, 32'h6,        32'h0,         0, 32'hFFFF_80FF, 2, 0};
        tbl[4]  = '{0, 2'b01, 1, 32'h6,        32'h0,         0, 32'h0000_80FF, 2, 0};
        tbl[5]  = '{1, 2'b00, 0, 32'hA,        32'h0000_00AB, 0, 32'h0,         3, 1};
        tbl[6]  = '{0, 2'b10, 0, 32'h8,        32'h0,         0, 32'h11AB_3344, 2, 0};
        tbl[7]  = '{0, 2'b10, 0, 32'h2,        32'h0,         1, 32'h0,         1, 0};
        tbl[8]  = '{1, 2'b01, 0, 32'h3,        32'h0000_5555, 1, 32'h0,         1, 0};
        tbl[9]  = '{0, 2'b11, 0, 32'h0,        32'h0,         1, 32'h0,         1, 0};
        tbl[10] = '{0, 2'b10, 0, 32'h400,      32'h0,         1, 32'h0,         1, 0};
        tbl[11] = '{1, 2'b01, 0, 32'h8,        32'h0000_5566, 0, 32'h0,         3, 1};
        tbl[12] = '{0, 2'b10, 0, 32'h8,        32'h0,         0, 32'h11AB_5566, 2, 0};
        tbl[13] = '{0, 2'b00, 0, 32'h7,        32'h0,         0, 32'hFFFF_FF80, 2, 0};
        tbl[14] = '{0, 2'b00, 1, 32'h4,        32'h0,         0, 32'h0000_0001, 2, 0};
        tbl[15] = '{1, 2'b00, 0, 32'hB,        32'hFFFF_FFCC, 0, 32'h0,         3, 1};
        tbl[16] = '{0, 2'b10, 0, 32'h8,        32'h0,         0, 32'hCCAB_5566, 2, 0};
        tbl[17] = '{0, 2'b10, 0, 32'h3FC,      32'h0,         0, 32'h1234_5678, 2, 0};

        // Asynchronous reset: outputs must clear without a clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("rst_done",  {31'd0, bus.done},      32'd0);
        chk("rst_err",   {31'd0, bus.err},       32'd0);
        chk("rst_rdata", bus.rdata,              32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_mem_read",  {31'd0, bus.mem_read},  32'd0);
        chk("rst_mem_address", bus.mem_address,  32'd0);
        chk("rst_mem_write_data", bus.mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) issue(tbl[i]);
        chk("mem2_after_stores", mem[2], 32'hCCAB_5566);

        // Word store with req held through busy: two back-to-back acceptances.
        v = '{1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 2, 1};
        @(negedge clk);
        drive(v);
        push(v);
        @(negedge clk);
        chk("hold_busy", {31'd0, bus.busy}, 32'd1);
        wait_done();
        @(negedge clk);
        chk("hold_idle_after_done", {31'd0, bus.busy}, 32'd0);
        push(v);
        @(negedge clk);
        chk("hold_second_accept", {31'd0, bus.busy}, 32'd1);
        bus.req = 1'b0;
        wait_done();
        @(negedge clk);
        chk("mem4_sw", mem[4], 32'hDEAD_BEEF);

        // Reset while the RMW read of a halfword store is in flight.
        v = '{1, 2'b01, 0, 32'hE, 32'h0000_7777, 0, 32'h0, 3, 1};
        @(negedge clk);
        drive(v);
        @(negedge clk);
        bus.req = 1'b0;
        chk("rmw_rd_read", {31'd0, bus.mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_write_count", 32'(wr_cnt), 32'd0);
        chk("abort_mem3", mem[3], 32'h0BAD_F00D);
        v = '{0, 2'b10, 0, 32'hC, 32'h0, 0, 32'h0BAD_F00D, 2, 0};
        issue(v);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
